// File: rtl/apple2_keyboard_if.sv
// CPU-side bus between the Apple II core and the keyboard latch at $C000/$C010.
interface apple2_keyboard_if;
  logic [15:0] cpu_addr;
  logic        kbd_cs;
  logic [7:0]  kbd_data;

  modport master (output cpu_addr, input kbd_cs, input kbd_data);
  modport slave  (input cpu_addr, output kbd_cs, output kbd_data);
endinterface

// File: rtl/apple2_keyboard.sv
// PS/2 set-2 receiver, ASCII translator and $C000 latch; key reaches the latch 2 clk after the stop-bit fall.
// No backpressure: an unread key is overwritten, or queued in a FIFO when KBD_FIFO_EN is defined.
module apple2_keyboard #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  apple2_keyboard_if.slave   bus,
  output logic               frame_err
);
  localparam logic [1:0] IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

  generate
    if (SYNC_STAGES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("apple2_keyboard: SYNC_STAGES >= 2 and power-of-2 FIFO_DEPTH >= 2 required");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic       clk_prev, fall, dat_s;
  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, code;
  logic       par, code_valid, rx_err, ovf;
  logic [TW-1:0] tmo_cnt;
  logic       brk, ext, shift, ctrl;
  logic [6:0] ascii;
  logic       key_vld, clr;
  logic [7:0] latch;

  assign bus.kbd_cs   = (bus.cpu_addr[15:4] == 12'hC00);
  assign bus.kbd_data = latch;
  assign clr          = (bus.cpu_addr == 16'hC010);
  assign dat_s        = dat_sync[SYNC_STAGES-1];
  assign fall         = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign frame_err    = rx_err | ovf;

  // Idle PS/2 lines are high, so the synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev <= clk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE; bit_cnt <= '0; shreg <= '0; par <= 1'b0;
      tmo_cnt <= '0; code_valid <= 1'b0; code <= '0; rx_err <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      rx_err     <= 1'b0;
      if (fall) begin
        tmo_cnt <= '0;
        case (state)
          IDLE: if (!dat_s) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_s;
            state <= STOP;
          end
          default: begin
            state <= IDLE;
            if ((^{shreg, par}) && dat_s) begin
              code_valid <= 1'b1;
              code       <= shreg;
            end else begin
              rx_err <= 1'b1;
            end
          end
        endcase
      end else if (state != IDLE) begin
        if (tmo_cnt == TMO) begin
          state   <= IDLE;
          rx_err  <= 1'b1;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TW'(1);
        end
      end
    end
  end

  function automatic logic [6:0] xlate(input logic [7:0] c, input logic e, input logic s, input logic k);
    logic [6:0] a;
    a = 7'h00;
    if (e) begin
      case (c)
        8'h6B: a = 7'h08;  8'h74: a = 7'h15;  8'h72: a = 7'h0A;  8'h75: a = 7'h0B;
        default: a = 7'h00;
      endcase
    end else begin
      case (c)
        8'h1C: a = 7'h41;  8'h32: a = 7'h42;  8'h21: a = 7'h43;  8'h23: a = 7'h44;
        8'h24: a = 7'h45;  8'h2B: a = 7'h46;  8'h34: a = 7'h47;  8'h33: a = 7'h48;
        8'h43: a = 7'h49;  8'h3B: a = 7'h4A;  8'h42: a = 7'h4B;  8'h4B: a = 7'h4C;
        8'h3A: a = 7'h4D;  8'h31: a = 7'h4E;  8'h44: a = 7'h4F;  8'h4D: a = 7'h50;
        8'h15: a = 7'h51;  8'h2D: a = 7'h52;  8'h1B: a = 7'h53;  8'h2C: a = 7'h54;
        8'h3C: a = 7'h55;  8'h2A: a = 7'h56;  8'h1D: a = 7'h57;  8'h22: a = 7'h58;
        8'h35: a = 7'h59;  8'h1A: a = 7'h5A;
        8'h16: a = s ? 7'h21 : 7'h31;  8'h1E: a = s ? 7'h40 : 7'h32;
        8'h26: a = s ? 7'h23 : 7'h33;  8'h25: a = s ? 7'h24 : 7'h34;
        8'h2E: a = s ? 7'h25 : 7'h35;  8'h36: a = s ? 7'h5E : 7'h36;
        8'h3D: a = s ? 7'h26 : 7'h37;  8'h3E: a = s ? 7'h2A : 7'h38;
        8'h46: a = s ? 7'h28 : 7'h39;  8'h45: a = s ? 7'h29 : 7'h30;
        8'h4E: a = s ? 7'h5F : 7'h2D;  8'h55: a = s ? 7'h2B : 7'h3D;
        8'h54: a = s ? 7'h7B : 7'h5B;  8'h5B: a = s ? 7'h7D : 7'h5D;
        8'h5D: a = s ? 7'h7C : 7'h5C;  8'h4C: a = s ? 7'h3A : 7'h3B;
        8'h52: a = s ? 7'h22 : 7'h27;  8'h0E: a = s ? 7'h7E : 7'h60;
        8'h41: a = s ? 7'h3C : 7'h2C;  8'h49: a = s ? 7'h3E : 7'h2E;
        8'h4A: a = s ? 7'h3F : 7'h2F;
        8'h29: a = 7'h20;  8'h5A: a = 7'h0D;  8'h66: a = 7'h08;  8'h76: a = 7'h1B;
        default: a = 7'h00;
      endcase
      // Only letters fold into control codes.
      if (k && a >= 7'h41 && a <= 7'h5A) a = a & 7'h1F;
    end
    return a;
  endfunction

  assign ascii   = xlate(code, ext, shift, ctrl);
  assign key_vld = code_valid && !brk && !(code inside {8'hF0, 8'hE0, 8'h12, 8'h59, 8'h14})
                   && (ascii != 7'h00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      brk <= 1'b0; ext <= 1'b0; shift <= 1'b0; ctrl <= 1'b0;
    end else if (code_valid) begin
      case (code)
        8'hF0:        brk <= 1'b1;
        8'hE0:        ext <= 1'b1;
        8'h12, 8'h59: begin shift <= !brk; brk <= 1'b0; ext <= 1'b0; end
        8'h14:        begin ctrl  <= !brk; brk <= 1'b0; ext <= 1'b0; end
        default:      begin brk <= 1'b0; ext <= 1'b0; end
      endcase
    end
  end

`ifdef KBD_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [6:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, push, pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && (!latch[7] || clr);
  assign push  = key_vld && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= ascii;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0; rd_ptr <= '0; latch <= 8'h00; ovf <= 1'b0;
    end else begin
      ovf <= key_vld && full && !pop;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
        latch  <= {1'b1, mem[rd_ptr[AW-1:0]]};
      end else if (clr) begin
        latch[7] <= 1'b0;
      end
    end
  end
`else
  assign ovf = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       latch    <= 8'h00;
    else if (key_vld) latch    <= {1'b1, ascii};
    else if (clr)     latch[7] <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_apple2_keyboard.sv
// Directed bench for apple2_keyboard: PS/2 frames in, $C000 latch and frame_err out.
module tb_apple2_keyboard;
  localparam int TMO = 1000;
  localparam int HB  = 20;

  logic clk = 1'b0;
  logic reset, ps2_clk, ps2_data, frame_err;
  int   checks = 0, errors = 0, err_pulses = 0;

  apple2_keyboard_if bus();

  apple2_keyboard #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .bus(bus), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frame(input logic [7:0] c, input logic bad_par, input logic stop);
    return {stop, (~^c) ^ bad_par, c, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      tick(HB);
      ps2_clk = 1'b0;
      tick(HB);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_code(input logic [7:0] c);
    send_bits(frame(c, 1'b0, 1'b1), 11);
    tick(HB);
  endtask

  task automatic strobe_clear;
    bus.cpu_addr = 16'hC010;
    tick(1);
    bus.cpu_addr = 16'h0000;
  endtask

  task automatic test_reset;
    reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; bus.cpu_addr = 16'h0000;
    tick(3);
    checks++; if (bus.kbd_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.kbd_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", frame_err); end
    reset = 1'b1;
    tick(3);
  endtask

  task automatic test_cs;
    logic [15:0] addrs [4] = '{16'hC00F, 16'hC010, 16'hC000, 16'hBFFF};
    logic        exp   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bus.cpu_addr = addrs[i];
      #1;
      checks++;
      if (bus.kbd_cs !== exp[i]) begin
        errors++; $display("FAIL kbd_cs addr %h got %b want %b", addrs[i], bus.kbd_cs, exp[i]);
      end
    end
    bus.cpu_addr = 16'h0000;
    tick(1);
  endtask

  task automatic test_latency;
    send_bits(frame(8'h1C, 1'b0, 1'b1), 10);
    ps2_data = 1'b1;
    tick(HB);
    ps2_clk = 1'b0;
    tick(3);
    checks++; if (bus.kbd_data !== 8'h00) begin errors++; $display("FAIL lat_early got %h want 00", bus.kbd_data); end
    tick(1);
    checks++; if (bus.kbd_data !== 8'hC1) begin errors++; $display("FAIL lat_load got %h want c1", bus.kbd_data); end
    tick(HB);
    ps2_clk = 1'b1;
    tick(HB);
    strobe_clear();
    checks++; if (bus.kbd_data !== 8'h41) begin errors++; $display("FAIL strobe_clr got %h want 41", bus.kbd_data); end
  endtask

  task automatic test_shift;
    logic [7:0] seq [8] = '{8'h12, 8'h16, 8'hF0, 8'h16, 8'hF0, 8'h12, 8'h16, 8'h00};
    logic [7:0] exp [7] = '{8'h41, 8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'hA1, 8'hB1};
    for (int i = 0; i < 7; i++) begin
      send_code(seq[i]);
      checks++;
      if (bus.kbd_data !== exp[i]) begin
        errors++; $display("FAIL shift_seq step %0d got %h want %h", i, bus.kbd_data, exp[i]);
      end
    end
  endtask

  task automatic test_ctrl_ext;
    send_code(8'h14); send_code(8'h21);
    checks++; if (bus.kbd_data !== 8'h83) begin errors++; $display("FAIL ctrl_c got %h want 83", bus.kbd_data); end
    send_code(8'hF0); send_code(8'h14);
    send_code(8'hE0); send_code(8'h74);
    checks++; if (bus.kbd_data !== 8'h95) begin errors++; $display("FAIL ext_right got %h want 95", bus.kbd_data); end
    send_code(8'h5A);
    checks++; if (bus.kbd_data !== 8'h8D) begin errors++; $display("FAIL enter got %h want 8d", bus.kbd_data); end
  endtask

  task automatic test_frame_errors;
    int e0;
    e0 = err_pulses;
    send_bits(frame(8'h1C, 1'b1, 1'b1), 11);
    tick(HB);
    checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL parity_err pulses got %0d want 1", err_pulses - e0); end
    checks++; if (bus.kbd_data !== 8'h8D) begin errors++; $display("FAIL parity_hold got %h want 8d", bus.kbd_data); end
    e0 = err_pulses;
    send_bits(frame(8'h1C, 1'b0, 1'b0), 11);
    tick(HB);
    ps2_data = 1'b1;
    checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL stop_err pulses got %0d want 1", err_pulses - e0); end
    checks++; if (bus.kbd_data !== 8'h8D) begin errors++; $display("FAIL stop_hold got %h want 8d", bus.kbd_data); end
  endtask

  task automatic test_timeout;
    int e0;
    e0 = err_pulses;
    send_bits(frame(8'h1C, 1'b0, 1'b1), 5);
    ps2_data = 1'b1;
    tick(TMO + 10);
    checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL timeout pulses got %0d want 1", err_pulses - e0); end
    checks++; if (bus.kbd_data !== 8'h8D) begin errors++; $display("FAIL timeout_hold got %h want 8d", bus.kbd_data); end
    send_code(8'h1C);
    checks++; if (bus.kbd_data !== 8'hC1) begin errors++; $display("FAIL after_timeout got %h want c1", bus.kbd_data); end
  endtask

  task automatic test_load_vs_clear;
    strobe_clear();
    checks++; if (bus.kbd_data !== 8'h41) begin errors++; $display("FAIL pre_clear got %h want 41", bus.kbd_data); end
    send_bits(frame(8'h1C, 1'b0, 1'b1), 10);
    ps2_data = 1'b1;
    tick(HB);
    ps2_clk = 1'b0;
    tick(3);
    bus.cpu_addr = 16'hC010;
    tick(1);
    bus.cpu_addr = 16'h0000;
    checks++; if (bus.kbd_data !== 8'hC1) begin errors++; $display("FAIL load_wins got %h want c1", bus.kbd_data); end
    tick(HB);
    ps2_clk = 1'b1;
    tick(HB);
  endtask

  task automatic test_reset_midframe;
    send_bits(frame(8'h32, 1'b0, 1'b1), 4);
    reset = 1'b0;
    #1;
    checks++; if (bus.kbd_data !== 8'h00) begin errors++; $display("FAIL midreset_data got %h want 00", bus.kbd_data); end
    tick(2);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    reset = 1'b1;
    tick(2);
    send_code(8'h32);
    checks++; if (bus.kbd_data !== 8'hC2) begin errors++; $display("FAIL midreset_key got %h want c2", bus.kbd_data); end
  endtask

  task automatic test_fifo;
    logic [7:0] fill [4] = '{8'h24, 8'h23, 8'h2B, 8'h34};
    int e0;
    send_code(8'h1C); send_code(8'h32); send_code(8'h21);
    checks++; if (bus.kbd_data !== 8'hC1) begin errors++; $display("FAIL fifo_head got %h want c1", bus.kbd_data); end
    strobe_clear();
    tick(1);
    checks++; if (bus.kbd_data !== 8'hC2) begin errors++; $display("FAIL fifo_pop1 got %h want c2", bus.kbd_data); end
    strobe_clear();
    tick(1);
    checks++; if (bus.kbd_data !== 8'hC3) begin errors++; $display("FAIL fifo_pop2 got %h want c3", bus.kbd_data); end
    e0 = err_pulses;
    for (int i = 0; i < 4; i++) send_code(fill[i]);
    checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL fifo_fill pulses got %0d want 0", err_pulses - e0); end
    send_code(8'h33);
    checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL fifo_ovf pulses got %0d want 1", err_pulses - e0); end
    checks++; if (bus.kbd_data !== 8'hC3) begin errors++; $display("FAIL fifo_hold got %h want c3", bus.kbd_data); end
  endtask

  initial begin
    test_reset();
    test_cs();
`ifdef KBD_FIFO_EN
    test_fifo();
`else
    test_latency();
    test_shift();
    test_ctrl_ext();
    test_frame_errors();
    test_timeout();
    test_load_vs_clear();
    test_reset_midframe();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apple2_keyboard.md
Name: apple2_keyboard

Overview:
- PS/2 keyboard front end for the Apple II core. Receives set-2 scan codes, translates them to Apple II uppercase ASCII and holds the result in the $C000 keyboard latch.
- Feeds the CPU read-data mux: data is placed on the bus when `kbd_cs` is high. The strobe is cleared by any CPU access to $C010.
- Sits directly upstream of the CPU data-input path.

Parameters:
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles with no PS/2 falling edge mid-frame before the receiver aborts the frame. At a 50 MHz `clk` this is 1 ms.
- `SYNC_STAGES`, default 2: flip-flop synchronizer depth on `ps2_clk` and `ps2_data`. Minimum 2.
- `FIFO_DEPTH`, default 4: key FIFO depth, power of 2. Used only when `KBD_FIFO_EN` is defined.

Ports:
- `clk`  in  1  system clock, same clock as the CPU.
- `reset`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `cpu_addr`  in  16  current CPU address bus.
- `kbd_cs`  out  1  combinational; high when `cpu_addr[15:4]` == 12'hC00 (range $C000-$C00F).
- `kbd_data`  out  8  registered; `{strobe, ascii[6:0]}`.
- `frame_err`  out  1  one-cycle pulse on a parity error, stop-bit error or timeout.

Behaviour:
- Reset:
  - All state clears asynchronously while `reset` = 0: `kbd_data` = 8'h00, `frame_err` = 0, receiver in IDLE, and the break, extended, shift and ctrl flags all 0.
  - Reset asserted mid-frame discards the partial frame. Reception restarts from IDLE.
- Synchronizer and edge detect:
  - `ps2_clk` and `ps2_data` pass through `SYNC_STAGES` flip-flops.
  - A falling edge is detected when the synchronized clock goes from 1 (previous cycle) to 0 (current cycle). This produces a one-cycle `fall` pulse.
- Receiver FSM (IDLE, DATA, PARITY, STOP), advancing only on `fall`:
  - IDLE -> DATA when the sampled data bit = 0 (start bit). A sampled 1 stays in IDLE.
  - DATA: shift in 8 bits, LSB first, using a 3-bit counter. Go to PARITY after bit 7.
  - PARITY: capture the parity bit, then go to STOP.
  - STOP: return to IDLE.
    - Frame is valid only if odd parity holds over data plus parity bit, and the stop bit = 1. A valid frame raises a one-cycle `code_valid` carrying the byte.
    - Otherwise pulse `frame_err` and discard the byte.
- Timeout:
  - A counter resets on every `fall` and increments in any state other than IDLE.
  - When the counter reaches `TIMEOUT_CYCLES`: FSM -> IDLE, pulse `frame_err` once, and clear the counter.
- Decoder, acting on `code_valid`:
  - 8'hF0: set `brk`.
  - 8'hE0: set `ext`.
  - 8'h12 or 8'h59: shift = !`brk`, then clear `brk` and `ext`.
  - 8'h14: ctrl = !`brk`, then clear `brk` and `ext`.
  - Any other code with `brk` = 1: no latch change, then clear `brk` and `ext`.
  - Any other code with `brk` = 0: look up the translation, then clear `ext`. If the table entry is 0 (unmapped), there is no latch change.
- Translation:
  - Letters map to uppercase ASCII regardless of shift. With ctrl = 1 the result is `ascii & 7'h1F`.
  - Digits and punctuation follow the US layout, with the shifted symbol when shift = 1.
  - Fixed codes: 8'h29 -> 7'h20, 8'h5A -> 7'h0D, 8'h66 -> 7'h08, 8'h76 -> 7'h1B.
  - Extended codes: E0 6B -> 7'h08, E0 74 -> 7'h15, E0 72 -> 7'h0A, E0 75 -> 7'h0B.
- Latch:
  - On a mapped make code, `kbd_data` <= `{1'b1, ascii}` on the next `clk` edge.
  - Total latency from the `fall` that samples the stop bit to `kbd_data` updating is 2 `clk` cycles.
- Strobe clear:
  - Any cycle with `cpu_addr` == 16'hC010 sets `kbd_data[7]` <= 0. `kbd_data[6:0]` is unchanged.
  - The clear applies to reads and writes alike and needs no `we` qualification.
- Simultaneous load and clear in the same cycle: the load wins and the strobe ends at 1.
- Without `KBD_FIFO_EN`, a new key overwrites an unread latch (original Apple II behaviour).

Optional Feature:
- Macro `KBD_FIFO_EN`.
- Defined:
  - Translated keys are pushed into a `FIFO_DEPTH`-entry FIFO.
  - When the strobe is 0 (or is being cleared this cycle) and the FIFO is non-empty, pop the head into the latch with strobe = 1. There is one cycle of latency from the push.
  - A push when the FIFO is full drops the new key and pulses `frame_err`.
  - A push and a pop in the same cycle are both honoured.
  - Reset empties the FIFO.
- Undefined: no FIFO, and keys load the latch directly as described above.

Test Plan:
- Frame 8'h1C ('A') -> `kbd_data` = 8'hC1 two cycles after the stop-bit `fall`. Then `cpu_addr` = 16'hC010 for one cycle -> `kbd_data` = 8'h41. `kbd_cs` = 1 for `cpu_addr` = 16'hC00F and 0 for 16'hC010.
- Frames 12, 16, F0 16, F0 12, 16 -> latch sequence 8'hA1 ('!'), then 8'hB1 ('1'). The break codes cause no latch change.
- Frames 14, 21 -> `kbd_data` = 8'h83 (ctrl-C). Frames E0 74 -> 8'h95. Frame 8'h5A -> 8'h8D.
- Frame 8'h1C with even parity -> `frame_err` pulses exactly once and `kbd_data` holds its prior value. Separately, send 5 bits, then idle for `TIMEOUT_CYCLES`+10 -> one `frame_err` pulse. A following frame 8'h1C still yields 8'hC1.
- Frame 8'h1C completing in the same cycle that `cpu_addr` = 16'hC010 -> `kbd_data` = 8'hC1 (load wins). Assert `reset` = 0 mid-frame, release, send 8'h32 -> 8'hC2.
- With `KBD_FIFO_EN`: send 1C, 32, 21 without reading -> 8'hC1 is shown. Each $C010 access advances the latch to 8'hC2, then 8'hC3. A 6th unread key with a full FIFO -> `frame_err` pulses.
